cpu_trace_buffer: RTL and testbench

- Synthesizable instruction-trace capture block: a parametrised, in-hardware successor to the simulation-only cycle monitor.
- Sits beside `datapath` and snoops the per-instruction fetch strobe, PC, IR, SP and flags into a circular RAM.
- Freezes capture on a PC-match or forced trigger, keeping a configurable pre/post-trigger window.
- Replays the captured window oldest-first through a simple read handshake for on-board debug.

---
 rtl/cpu_trace_buffer.sv | 159 +++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture: snoops fetches into a circular RAM, freezes on a trigger with a
// pre/post window, then replays oldest-first. Define TRACE_CYCLE_STAMP_EN to add a cycle stamp.
module cpu_trace_buffer #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned POST_TRIG = 32,
    parameter int unsigned AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          force_trig,
    input  logic          trig_en,
    input  logic [15:0]   trig_pc,
    input  logic          trace_valid,
    input  logic [15:0]   trace_pc,
    input  logic [7:0]    trace_ir,
    input  logic [15:0]   trace_sp,
    input  logic [3:0]    trace_flags,
    input  logic          rd_en,
    output logic          rd_valid,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [75:0]   rd_data,
`else
    output logic [43:0]   rd_data,
`endif
    output logic [1:0]    state,
    output logic [AW:0]   entries,
    output logic          done
);

    localparam int unsigned ENTRY_W = $bits(rd_data);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic [AW:0]        entries_q, entries_d;
    logic [AW-1:0]      rd_ptr;
    logic               capturing, wr_fire, rd_fire, trig_hit, entries_full;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] mem [DEPTH];

    assign capturing    = (state_q == StArmed) || (state_q == StPost);
    assign wr_fire      = !arm && capturing && trace_valid;
    assign rd_fire      = !arm && (state_q == StDone) && rd_en && (entries_q != '0);
    assign trig_hit     = (trig_en && trace_valid && (trace_pc == trig_pc)) || force_trig;
    assign entries_full = (entries_q == (AW+1)'(DEPTH));
    // Oldest valid entry; advances automatically as reads decrement entries.
    assign rd_ptr       = wr_ptr_q - entries_q[AW-1:0];

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] stamp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stamp_q <= '0;
        end else if (arm) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + 32'd1;
        end
    end

    assign wr_entry = {stamp_q, trace_pc, trace_ir, trace_sp, trace_flags};
`else
    assign wr_entry = {trace_pc, trace_ir, trace_sp, trace_flags};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            post_cnt_q <= '0;
            entries_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            post_cnt_q <= post_cnt_d;
            entries_q  <= entries_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        post_cnt_d = post_cnt_q;
        entries_d  = entries_q;
        if (arm) begin
            state_d    = StArmed;
            wr_ptr_d   = '0;
            post_cnt_d = '0;
            entries_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (!entries_full) begin
                    entries_d = entries_q + (AW+1)'(1);
                end
            end
            if (rd_fire) begin
                entries_d = entries_q - (AW+1)'(1);
            end
            unique case (state_q)
                StArmed: begin
                    if (trig_hit) begin
                        if (POST_TRIG == 0) begin
                            state_d = StDone;
                        end else begin
                            state_d    = StPost;
                            post_cnt_d = AW'(POST_TRIG);
                        end
                    end
                end
                StPost: begin
                    if (trace_valid) begin
                        post_cnt_d = post_cnt_q - AW'(1);
                        if (post_cnt_q == AW'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state = state_q;
        done  = (state_q == StDone);
    end

    assign entries = entries_q;

    // Plain write port, no reset, so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer (DEPTH=8, POST_TRIG=4) with a queue-based capture model.
`timescale 1ns/1ps
module tb_cpu_trace_buffer;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned POST_TRIG = 4;
    localparam int unsigned AW        = 3;
`ifdef TRACE_CYCLE_STAMP_EN
    localparam int EW = 76;
`else
    localparam int EW = 44;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          force_trig = 1'b0;
    logic          trig_en = 1'b0;
    logic [15:0]   trig_pc = '0;
    logic          trace_valid = 1'b0;
    logic [15:0]   trace_pc = '0;
    logic [7:0]    trace_ir = '0;
    logic [15:0]   trace_sp = '0;
    logic [3:0]    trace_flags = '0;
    logic          rd_en = 1'b0;
    logic          rd_valid;
    logic [EW-1:0] rd_data;
    logic [1:0]    state;
    logic [AW:0]   entries;
    logic          done;

    cpu_trace_buffer #(
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .force_trig  (force_trig),
        .trig_en     (trig_en),
        .trig_pc     (trig_pc),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_ir    (trace_ir),
        .trace_sp    (trace_sp),
        .trace_flags (trace_flags),
        .rd_en       (rd_en),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .state       (state),
        .entries     (entries),
        .done        (done)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            mstate = 0;
    int            mpost  = 0;
    logic [31:0]   mstamp = '0;
    logic [EW-1:0] cap_q[$];
    logic [EW-1:0] exp_q[$];
    logic [15:0]   got_pc_q[$];
    logic [31:0]   got_stamp_q[$];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding expected entry.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd_valid: got rd_valid=1 data %0h expected no read",
                             rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                    got_pc_q.push_back(rd_data[43:28]);
`ifdef TRACE_CYCLE_STAMP_EN
                    got_stamp_q.push_back(rd_data[75:44]);
`endif
                end
            end
        end
    end

    task automatic cap_push(input logic [EW-1:0] ent);
        cap_q.push_back(ent);
        if (cap_q.size() > DEPTH) void'(cap_q.pop_front());
    endtask

    task automatic step(input logic tv, input logic [15:0] pc, input logic ft, input logic ar,
                        input logic rd);
        logic [EW-1:0] ent;
        logic          trig;
        trace_valid = tv;
        trace_pc    = pc;
        trace_ir    = 8'($urandom);
        trace_sp    = 16'($urandom);
        trace_flags = 4'($urandom);
        force_trig  = ft;
        arm         = ar;
        rd_en       = rd;
`ifdef TRACE_CYCLE_STAMP_EN
        ent = {mstamp, pc, trace_ir, trace_sp, trace_flags};
`else
        ent = {pc, trace_ir, trace_sp, trace_flags};
`endif
        if (ar) begin
            cap_q.delete();
            mpost  = 0;
            mstate = 1;
        end else begin
            case (mstate)
                1: begin
                    if (tv) cap_push(ent);
                    trig = (trig_en && tv && (pc == trig_pc)) || ft;
                    if (trig) begin
                        if (POST_TRIG == 0) begin
                            mstate = 3;
                        end else begin
                            mstate = 2;
                            mpost  = POST_TRIG;
                        end
                    end
                end
                2: begin
                    if (tv) begin
                        cap_push(ent);
                        mpost--;
                        if (mpost == 0) mstate = 3;
                    end
                end
                3: begin
                    if (rd && cap_q.size() > 0) exp_q.push_back(cap_q.pop_front());
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        mstamp      = ar ? 32'd0 : mstamp + 32'd1;
        arm         = 1'b0;
        force_trig  = 1'b0;
        trace_valid = 1'b0;
        rd_en       = 1'b0;
        check("state", EW'(state), EW'(mstate));
        check("entries", EW'(entries), EW'(cap_q.size()));
        check("done", EW'(done), EW'(mstate == 3));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_all(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("pending_reads", EW'(exp_q.size()), EW'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        arm = 1'b0; force_trig = 1'b0; trace_valid = 1'b0; rd_en = 1'b0;
        #3;
        mstate = 0;
        mpost  = 0;
        mstamp = '0;
        cap_q.delete();
        exp_q.delete();
        check("rst_state", EW'(state), EW'(0));
        check("rst_entries", EW'(entries), EW'(0));
        check("rst_rd_valid", EW'(rd_valid), EW'(0));
        check("rst_rd_data", rd_data, EW'(0));
        check("rst_done", EW'(done), EW'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        do_reset();

        // No arm: fetches, triggers and reads have no effect.
        trig_en = 1'b1;
        trig_pc = 16'h0005;
        for (int i = 0; i < 20; i++) step(1'b1, 16'(i), 1'(i == 7), 1'b0, 1'(i % 3 == 0));
        idle(2);

        // PC-match trigger on third fetch.
        trig_en = 1'b1;
        trig_pc = 16'h0102;
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
        check("pc_trig_entries", EW'(entries), EW'(7));
        check("pc_trig_done", EW'(done), EW'(1));
        got_pc_q.delete();
        read_all(8);
        check("pc_trig_reads", EW'(got_pc_q.size()), EW'(7));
        if (got_pc_q.size() == 7) begin
            for (int i = 0; i < 7; i++) check("pc_trig_order", EW'(got_pc_q[i]), EW'(16'h0100 + i));
        end

        // Forced trigger with wrap-around, then nine reads.
        trig_en = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 16'h0200 + 16'(i), 1'(i == 11), 1'b0, 1'b0);
        check("wrap_entries", EW'(entries), EW'(8));
        got_pc_q.delete();
        read_all(9);
        check("wrap_reads", EW'(got_pc_q.size()), EW'(8));
        if (got_pc_q.size() == 8) begin
            check("wrap_first_pc", EW'(got_pc_q[0]), EW'(16'h0208));
            check("wrap_last_pc", EW'(got_pc_q[7]), EW'(16'h020F));
        end
        check("wrap_entries_empty", EW'(entries), EW'(0));

        // arm coincident with trace_valid: entry dropped.
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0333, 1'b0, 1'b1, 1'b0);
        check("arm_beats_fetch", EW'(entries), EW'(0));

        // Fetches 5 cycles apart; stamps step by exactly 5.
        trig_en = 1'b1;
        trig_pc = 16'h0400;
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 16'h0400 + 16'(k), 1'b0, 1'b0, 1'b0);
            if (k < 4) idle(4);
        end
        got_stamp_q.delete();
        read_all(5);
`ifdef TRACE_CYCLE_STAMP_EN
        check("stamp_reads", EW'(got_stamp_q.size()), EW'(5));
        for (int k = 1; k < got_stamp_q.size(); k++)
            check("stamp_delta", EW'(got_stamp_q[k] - got_stamp_q[k-1]), EW'(5));
`endif

        // Randomized rounds with stray arms, triggers, reads and one mid-run reset.
        for (int r = 0; r < 30; r++) begin
            trig_en = 1'($urandom_range(0, 1));
            trig_pc = 16'h0300 + 16'($urandom_range(0, 15));
            step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
            for (int c = 0; c < 40; c++) begin
                step(1'($urandom_range(0, 9) < 6), 16'h0300 + 16'($urandom_range(0, 15)),
                     1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 39) == 0),
                     1'($urandom_range(0, 1)));
                if (r == 15 && c == 20) do_reset();
            end
            read_all(10);
        end

        idle(2);
        check("final_pending", EW'(exp_q.size()), EW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
